mips: RTL and testbench
=======================

# mips

Multi-cycle 32-bit MIPS subset processor with instruction memory, byte-addressed data memory, a 32-entry register file and an FSM controller in one top level. Each instruction runs as a sequence of FSM states of 3–5 cycles. The bench preloads all three memories by hierarchical path and observes PC, instruction, FSM state and register/memory contents.

## Interface
- No parameters.
- clock  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- Observable internals at top level, with fixed names:
  - PC (32): program counter.
  - INSTR (32): instruction register.
  - WD (32): GPR write data.
- Observable sub-instances, with fixed names:
  - IM_17.rom: 1024×32, word-indexed.
  - DM_17.ram: 1024×8.
  - GPR_17.register: 32×32.
  - CTRL_17.fsm: 4-bit state.

## Operation
- ISA:
  - R-type: addu, subu, and, or, slt, jr.
  - I-type: addiu, ori, lui, lw, sw, beq.
  - J-type: j, jal.
  - Any other opcode/funct executes as a NOP: FETCH→DECODE→FETCH.
- IM read: rom[PC[11:2]].
- DM addressing:
  - Byte address is ALU result [9:0].
  - Words are little-endian: word at address a = {ram[a+3], ram[a+2], ram[a+1], ram[a]}.
- Arithmetic and extension:
  - All arithmetic is modulo 2^32; no overflow traps.
  - slt is signed.
  - addiu, lw, sw, beq sign-extend imm16.
  - ori zero-extends imm16.
  - lui gives {imm16, 16'h0}.
- Branch and jump targets:
  - Branch target = PC+4 + (sext(imm16) << 2).
  - j/jal target = {PC+4[31:28], imm26, 2'b00}.
  - jal writes PC+4 to $31.
- GPR:
  - register[0] always reads 0; writes to it are ignored.
  - Two combinational read ports, one synchronous write port.
  - Write destinations: rd for R-type, rt for I-type loads/ALU ops, 31 for jal.
  - WD selects among ALUOut, the memory data register, or PC+4 (jal).
- FSM states, values shown in CTRL_17.fsm:
  - 0 FETCH: INSTR ← IM; PC ← PC+4.
  - 1 DECODE: latch A ← GPR[rs], B ← GPR[rt]; ALUOut ← branch target.
  - 2 MEMADR: ALUOut ← A + sext(imm).
  - 3 MEMRD: MDR ← DM word.
  - 4 MEMWB: GPR[rt] ← MDR.
  - 5 MEMWR: DM word ← B.
  - 6 EXE: ALUOut ← A op B, or A op imm.
  - 7 ALUWB: GPR[dst] ← ALUOut.
  - 8 BRANCH: if A == B, PC ← ALUOut.
  - 9 JUMP: PC ← target, or A for jr; jal also writes $31 ← PC (already PC+4).
- Transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR (lw/sw), EXE (R-ALU/I-ALU/lui), BRANCH (beq), JUMP (j/jal/jr), or FETCH (NOP).
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB.
  - EXE → ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, JUMP → FETCH.

## Timing
- On a rising edge with reset==0:
  - PC ← 0x0000_3000, fsm ← FETCH (0).
  - INSTR, A, B, ALUOut, MDR ← 0.
  - GPR, DM and IM contents are NOT altered, so bench preloads survive.
- Reset takes priority over any in-flight state. Reset during MEMWR or ALUWB suppresses that cycle's write.
- CPI:
  - lw 5.
  - R-type, I-ALU, lui, sw 4.
  - beq, j, jal, jr 3.
  - NOP 2.
- All register, memory and PC updates happen at the rising edge that ends the named state. DM and GPR writes happen only in their write states.
- Fetch reads: IM read is combinational from PC; INSTR latches at the end of FETCH.
- Simultaneous read/write of the same GPR in one cycle: the read returns the old value. The FSM never requires forwarding.
- PC wrap-around beyond the IM index is ignored; rom index uses PC[11:2].

## Structure
- Shared package mips_pkg holds:
  - opcode and funct constants;
  - FSM state encodings 0–9;
  - ALU-op enum;
  - RESET_PC = 32'h0000_3000.
- Sub-modules, instantiated by the top-level mips with the instance names above:
  - im, dm, gpr: plain storage.
  - alu: combinational.
  - ctrl: the FSM plus decode. This is the natural standalone sub-module.
- The datapath (PC, INSTR, A, B, ALUOut, MDR, muxes) lives in the top level.

## Test plan
- Reset: hold reset=0 for 2 edges, release → PC=0x3000, fsm=0; the first instruction is fetched from rom[0x000]. A preloaded $t0 is unchanged.
- ALU: ori $t0,$0,0x1234; lui $t1,0xABCD; addu $t2,$t0,$t1 → $t0=0x00001234, $t1=0xABCD0000, $t2=0xABCD1234. Each instruction takes 4 cycles.
- Memory: sw $t2,4($0); lw $t3,4($0) → ram[7..4]=AB,CD,12,34; $t3=0xABCD1234; lw takes 5 cycles.
- Branch: beq $t0,$t0,+2 → PC = branch PC+4+8. beq with unequal operands → PC = branch PC+4. Each takes 3 cycles.
- Jumps: jal to 0x3020 from 0x3008 → $ra=0x0000300C, PC=0x3020. Then jr $ra → PC=0x300C.
- Corner cases:
  - slt with $t0=0xFFFFFFFF, $t1=1 → result 1.
  - addu writing $0 leaves it 0.
  - reset asserted in MEMWR → DM unchanged, fsm=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS subset: opcodes, functs,
// controller states, ALU operations and the reset vector.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXE    = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_LUI = 3'd5
  } alu_op_e;

  // Second ALU operand source; SRC_BR is the word-scaled branch offset.
  typedef enum logic [1:0] {
    SRC_B    = 2'd0,
    SRC_SEXT = 2'd1,
    SRC_ZEXT = 2'd2,
    SRC_BR   = 2'd3
  } src_b_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU; slt compares as two's-complement.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] y
);
  logic signed [31:0] a_s, b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    case (alu_op_e'(op))
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, (a_s < b_s)};
      ALU_LUI: y = {b[15:0], 16'h0000};
      default: y = a + b;
    endcase
  end
endmodule

// File: rtl/mips_ctrl.sv
// Controller: instruction decode plus the multi-cycle state machine.
module mips_ctrl
  import mips_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] state,
  output logic [2:0] alu_op,
  output logic [1:0] src_b,
  output logic       reg_dst_rd,
  output logic       is_jal,
  output logic       is_jr
);
  state_e  fsm;
  alu_op_e alu_sel;
  src_b_e  src_sel;
  logic    is_r_alu, is_i_alu, is_mem, is_beq, is_jump;

  always_comb begin
    is_r_alu = (op == OP_RTYPE) &&
               (funct inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT});
    is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
    is_i_alu = op inside {OP_ADDIU, OP_ORI, OP_LUI};
    is_mem   = op inside {OP_LW, OP_SW};
    is_beq   = (op == OP_BEQ);
    is_jal   = (op == OP_JAL);
    is_jump  = is_jr || is_jal || (op == OP_J);
    reg_dst_rd = (op == OP_RTYPE);
  end

  // DECODE precomputes the branch target; MEMADR forms base+offset.
  always_comb begin
    alu_sel = ALU_ADD;
    src_sel = SRC_SEXT;
    if (fsm == S_DECODE) begin
      src_sel = SRC_BR;
    end else if (fsm == S_EXE) begin
      if (op == OP_RTYPE) begin
        src_sel = SRC_B;
        case (funct)
          FN_SUBU: alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_SLT:  alu_sel = ALU_SLT;
          default: alu_sel = ALU_ADD;
        endcase
      end else if (op == OP_ORI) begin
        alu_sel = ALU_OR;
        src_sel = SRC_ZEXT;
      end else if (op == OP_LUI) begin
        alu_sel = ALU_LUI;
        src_sel = SRC_ZEXT;
      end
    end
  end

  assign alu_op = alu_sel;
  assign src_b  = src_sel;
  assign state  = fsm;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fsm <= S_FETCH;
    end else begin
      case (fsm)
        S_FETCH:  fsm <= S_DECODE;
        S_DECODE: begin
          if (is_mem)                     fsm <= S_MEMADR;
          else if (is_r_alu || is_i_alu)  fsm <= S_EXE;
          else if (is_beq)                fsm <= S_BRANCH;
          else if (is_jump)               fsm <= S_JUMP;
          else                            fsm <= S_FETCH;
        end
        S_MEMADR: fsm <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  fsm <= S_MEMWB;
        S_EXE:    fsm <= S_ALUWB;
        default:  fsm <= S_FETCH;
      endcase
    end
  end
endmodule

// File: rtl/mips_dm.sv
// Byte-addressed data memory, little-endian word access, combinational read.
module mips_dm (
  input  logic        clock,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  logic [7:0] ram [0:1023];
  logic [9:0] a1, a2, a3;

  // Byte lanes wrap inside the 1 KiB array.
  assign a1 = addr + 10'd1;
  assign a2 = addr + 10'd2;
  assign a3 = addr + 10'd3;
  assign rd = {ram[a3], ram[a2], ram[a1], ram[addr]};

  always_ff @(posedge clock) begin
    if (we) begin
      ram[addr] <= wd[7:0];
      ram[a1]   <= wd[15:8];
      ram[a2]   <= wd[23:16];
      ram[a3]   <= wd[31:24];
    end
  end
endmodule

// File: rtl/mips_gpr.sv
// 32x32 register file: two combinational read ports, one synchronous write;
// $0 reads as zero and ignores writes.
module mips_gpr (
  input  logic        clock,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] register [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : register[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : register[ra2];

  always_ff @(posedge clock) begin
    if (we && (wa != 5'd0)) register[wa] <= wd;
  end
endmodule

// File: rtl/mips_im.sv
// Instruction memory: 1024 words, combinational read, with a load port
// that the processor ties off.
module mips_im (
  input  logic        clock,
  input  logic        we,
  input  logic [9:0]  wa,
  input  logic [31:0] wd,
  input  logic [9:0]  addr,
  output logic [31:0] rd
);
  logic [31:0] rom [0:1023];

  always_ff @(posedge clock) begin
    if (we) rom[wa] <= wd;
  end

  assign rd = rom[addr];
endmodule

// File: rtl/mips.sv
// Multi-cycle MIPS subset processor: datapath registers and muxes, with
// storage, ALU and controller as sub-instances.
module mips
  import mips_pkg::*;
(
  input logic clock,
  input logic reset
);
  logic [31:0] PC, INSTR, WD;
  logic [31:0] pc_d, instr_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic [3:0]  state;
  state_e      st;
  logic [2:0]  alu_op;
  logic [1:0]  src_b;
  logic        reg_dst_rd, is_jal, is_jr;
  logic [31:0] im_rd, dm_rd, rd1, rd2, alu_a, alu_b, alu_y, imm_sext;
  logic [4:0]  wa;
  logic        gpr_we, dm_we;

  assign st       = state_e'(state);
  assign imm_sext = sext16(INSTR[15:0]);

  mips_im IM_17 (
    .clock(clock), .we(1'b0), .wa(10'd0), .wd(32'd0),
    .addr(PC[11:2]), .rd(im_rd)
  );

  mips_dm DM_17 (
    .clock(clock), .we(dm_we), .addr(alu_out_q[9:0]), .wd(b_q), .rd(dm_rd)
  );

  mips_gpr GPR_17 (
    .clock(clock), .ra1(INSTR[25:21]), .ra2(INSTR[20:16]),
    .rd1(rd1), .rd2(rd2), .we(gpr_we), .wa(wa), .wd(WD)
  );

  mips_alu ALU_17 (.a(alu_a), .b(alu_b), .op(alu_op), .y(alu_y));

  mips_ctrl CTRL_17 (
    .clock(clock), .reset(reset), .op(INSTR[31:26]), .funct(INSTR[5:0]),
    .state(state), .alu_op(alu_op), .src_b(src_b),
    .reg_dst_rd(reg_dst_rd), .is_jal(is_jal), .is_jr(is_jr)
  );

  always_comb begin
    alu_a = (st == S_DECODE) ? PC : a_q;
    case (src_b_e'(src_b))
      SRC_B:    alu_b = b_q;
      SRC_ZEXT: alu_b = {16'h0000, INSTR[15:0]};
      SRC_BR:   alu_b = {imm_sext[29:0], 2'b00};
      default:  alu_b = imm_sext;
    endcase
  end

  // Write-back steering; reset low gates every architectural write.
  always_comb begin
    dm_we  = reset && (st == S_MEMWR);
    gpr_we = reset && ((st == S_MEMWB) || (st == S_ALUWB) ||
                       ((st == S_JUMP) && is_jal));
    if (st == S_MEMWB) begin
      wa = INSTR[20:16];
      WD = mdr_q;
    end else if (st == S_JUMP) begin
      wa = 5'd31;
      WD = PC;
    end else begin
      wa = reg_dst_rd ? INSTR[15:11] : INSTR[20:16];
      WD = alu_out_q;
    end
  end

  always_comb begin
    pc_d      = PC;
    instr_d   = INSTR;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    case (st)
      S_FETCH: begin
        instr_d = im_rd;
        pc_d    = PC + 32'd4;
      end
      S_DECODE: begin
        a_d       = rd1;
        b_d       = rd2;
        alu_out_d = alu_y;
      end
      S_MEMADR, S_EXE: alu_out_d = alu_y;
      S_MEMRD:  mdr_d = dm_rd;
      S_BRANCH: if (a_q == b_q) pc_d = alu_out_q;
      S_JUMP:   pc_d = is_jr ? a_q : {PC[31:28], INSTR[25:0], 2'b00};
      default:  ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      PC        <= RESET_PC;
      INSTR     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
    end else begin
      PC        <= pc_d;
      INSTR     <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
    end
  end
endmodule

// File: tb/tb_mips.sv
// Bench for the multi-cycle MIPS: one table row per instruction with its
// expected cycle count, next PC and architectural effect.
module tb_mips;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  // kind: 0 = no result check, 1 = GPR[idx] == val, 2 = DM word at idx == val
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [3:0]  cyc;
    logic [31:0] npc;
    logic [1:0]  kind;
    logic [9:0]  idx;
    logic [31:0] val;
  } vec_t;

  localparam int NV = 17;
  vec_t v [NV];

  mips DUT (.clock(clock), .reset(reset));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] dm_word(input int a);
    return {DUT.DM_17.ram[a+3], DUT.DM_17.ram[a+2], DUT.DM_17.ram[a+1], DUT.DM_17.ram[a]};
  endfunction

  initial begin
    v[0]  = '{32'h3000, 32'h34081234, 4'd4, 32'h3004, 2'd1, 10'd8,  32'h0000_1234}; // ori $t0
    v[1]  = '{32'h3004, 32'h3C09ABCD, 4'd4, 32'h3008, 2'd1, 10'd9,  32'hABCD_0000}; // lui $t1
    v[2]  = '{32'h3008, 32'h01095021, 4'd4, 32'h300C, 2'd1, 10'd10, 32'hABCD_1234}; // addu $t2
    v[3]  = '{32'h300C, 32'hAC0A0004, 4'd4, 32'h3010, 2'd2, 10'd4,  32'hABCD_1234}; // sw 4($0)
    v[4]  = '{32'h3010, 32'h8C0B0004, 4'd5, 32'h3014, 2'd1, 10'd11, 32'hABCD_1234}; // lw $t3
    v[5]  = '{32'h3014, 32'h11080002, 4'd3, 32'h3020, 2'd0, 10'd0,  32'h0};         // beq taken
    v[6]  = '{32'h3020, 32'h11090005, 4'd3, 32'h3024, 2'd0, 10'd0,  32'h0};         // beq not taken
    v[7]  = '{32'h3024, 32'h0C000C20, 4'd3, 32'h3080, 2'd1, 10'd31, 32'h0000_3028}; // jal 0x3080
    v[8]  = '{32'h3080, 32'h03E00008, 4'd3, 32'h3028, 2'd0, 10'd0,  32'h0};         // jr $ra
    v[9]  = '{32'h3028, 32'h240CFFFF, 4'd4, 32'h302C, 2'd1, 10'd12, 32'hFFFF_FFFF}; // addiu -1
    v[10] = '{32'h302C, 32'h240D0001, 4'd4, 32'h3030, 2'd1, 10'd13, 32'h0000_0001}; // addiu 1
    v[11] = '{32'h3030, 32'h018D702A, 4'd4, 32'h3034, 2'd1, 10'd14, 32'h0000_0001}; // slt signed
    v[12] = '{32'h3034, 32'h01090021, 4'd4, 32'h3038, 2'd1, 10'd0,  32'h0000_0000}; // addu $0
    v[13] = '{32'h3038, 32'h01287823, 4'd4, 32'h303C, 2'd1, 10'd15, 32'hABCC_EDCC}; // subu
    v[14] = '{32'h303C, 32'hFC000000, 4'd2, 32'h3040, 2'd0, 10'd0,  32'h0};         // unknown -> NOP
    v[15] = '{32'h3040, 32'h01488024, 4'd4, 32'h3044, 2'd1, 10'd16, 32'h0000_1234}; // and
    v[16] = '{32'h3044, 32'h01098825, 4'd4, 32'h3048, 2'd1, 10'd17, 32'hABCD_1234}; // or

    for (int i = 0; i < NV; i++) DUT.IM_17.rom[v[i].addr[11:2]] = v[i].instr;
    DUT.IM_17.rom[18] = 32'hAC0A0008;  // sw $t2,8($0) at 0x3048
    DUT.GPR_17.register[0] = 32'd0;
    DUT.GPR_17.register[8] = 32'hDEAD_BEEF;
    for (int k = 8; k < 12; k++) DUT.DM_17.ram[k] = 8'h55;

    // Reset held for two edges.
    reset = 1'b0;
    step(2);
    chk("reset_pc", DUT.PC, 32'h0000_3000);
    chk("reset_fsm", 32'(DUT.CTRL_17.fsm), 32'd0);
    chk("reset_instr", DUT.INSTR, 32'd0);
    chk("reset_keeps_t0", DUT.GPR_17.register[8], 32'hDEAD_BEEF);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(1);
      chk($sformatf("instr[%0d]", i), DUT.INSTR, v[i].instr);
      step(int'(v[i].cyc) - 2);
      chk($sformatf("busy[%0d]", i), {31'd0, (DUT.CTRL_17.fsm != 0)}, 32'd1);
      step(1);
      chk($sformatf("done_fsm[%0d]", i), 32'(DUT.CTRL_17.fsm), 32'd0);
      chk($sformatf("pc[%0d]", i), DUT.PC, v[i].npc);
      if (v[i].kind == 2'd1)
        chk($sformatf("gpr[%0d]", i), DUT.GPR_17.register[v[i].idx[4:0]], v[i].val);
      else if (v[i].kind == 2'd2)
        chk($sformatf("dm[%0d]", i), dm_word(int'(v[i].idx)), v[i].val);
    end
    chk("ram7", 32'(DUT.DM_17.ram[7]), 32'h0000_00AB);
    chk("ram4", 32'(DUT.DM_17.ram[4]), 32'h0000_0034);

    // Reset arriving while the store sits in MEMWR must cancel the write.
    step(3);
    chk("sw_in_memwr", 32'(DUT.CTRL_17.fsm), 32'd5);
    reset = 1'b0;
    step(1);
    chk("memwr_reset_dm", dm_word(8), 32'h5555_5555);
    chk("memwr_reset_fsm", 32'(DUT.CTRL_17.fsm), 32'd0);
    chk("memwr_reset_pc", DUT.PC, 32'h0000_3000);
    chk("memwr_reset_instr", DUT.INSTR, 32'd0);
    reset = 1'b1;
    step(1);
    chk("refetch_instr", DUT.INSTR, 32'h34081234);
    chk("refetch_pc", DUT.PC, 32'h0000_3004);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
